// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master between the instruction-fetch
// port (read-only) and the load/store data port. One transfer is in flight at a time.
module axi_mem_arbiter #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  i_req,
  input  logic [ADDRESS-1:0]    i_addr,
  output logic                  i_done,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDRESS-1:0]    d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  start_read_o,
  output logic                  start_write_o,
  output logic [ADDRESS-1:0]    addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic                  mem_done_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [1:0]            grant_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;

  state_t state;
  owner_t owner;
  owner_t last_grant;
  logic   op_write;

  logic pick_data;
  logic pick_write;

  // On a tie the port that did not win last time gets the bus.
  always_comb begin
    pick_data  = d_req && (!i_req || last_grant == OWN_INSTR);
    pick_write = pick_data && d_we;
  end

  // NOTE: every register here uses non-blocking assignment so all state and
  // outputs update together from values sampled at the same clock edge.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state         <= IDLE;
      owner         <= OWN_INSTR;
      last_grant    <= OWN_INSTR;
      op_write      <= 1'b0;
      i_done        <= 1'b0;
      i_rdata       <= '0;
      d_done        <= 1'b0;
      d_rdata       <= '0;
      start_read_o  <= 1'b0;
      start_write_o <= 1'b0;
      addr_o        <= '0;
      wdata_o       <= '0;
      grant_o       <= 2'b00;
      busy_o        <= 1'b0;
    end else begin
      start_read_o  <= 1'b0;
      start_write_o <= 1'b0;
      i_done        <= 1'b0;
      d_done        <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner         <= pick_data ? OWN_DATA : OWN_INSTR;
            last_grant    <= pick_data ? OWN_DATA : OWN_INSTR;
            op_write      <= pick_write;
            addr_o        <= pick_data ? d_addr : i_addr;
            wdata_o       <= pick_write ? d_wdata : '0;
            grant_o       <= pick_data ? 2'b10 : 2'b01;
            busy_o        <= 1'b1;
            start_read_o  <= !pick_write;
            start_write_o <= pick_write;
            state         <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mem_done_i) begin
            if (!op_write) begin
              if (owner == OWN_DATA) d_rdata <= rdata_i;
              else                   i_rdata <= rdata_i;
            end
            i_done <= (owner == OWN_INSTR);
            d_done <= (owner == OWN_DATA);
            state  <= DONE;
          end
        end
        DONE: begin
          grant_o <= 2'b00;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
